// File: rtl/instruction_fetch.sv
// Instruction fetch unit: drives instruction-memory reads from the PC, holds the
// fetched word for decode, and steers the PC load port for stalls and redirects.
module instruction_fetch (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pc_in,
    output logic        pc_ld,
    output logic [15:0] pc_ld_addr,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_data,
    output logic [15:0] ir_out,
    output logic [15:0] instr_addr,
    output logic        ir_valid,
    input  logic        ir_ready,
    input  logic        redirect,
    input  logic [15:0] redirect_addr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        FULL  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] drain_addr;
    logic        capture;
    logic        start_drain;
    logic        release_ir;

    // State register plus the instruction register and the orphaned-request address
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            ir_out     <= 16'h0000;
            instr_addr <= 16'h0000;
            ir_valid   <= 1'b0;
            drain_addr <= 16'h0000;
        end else begin
            state <= state_next;
            if (capture) begin
                ir_out     <= mem_data;
                instr_addr <= pc_in;
                ir_valid   <= 1'b1;
            end else if (release_ir) begin
                ir_valid <= 1'b0;
            end
            if (start_drain) begin
                drain_addr <= pc_in;
            end
        end
    end

    always_comb begin
        state_next  = state;
        mem_req     = 1'b0;
        mem_addr    = pc_in;
        capture     = 1'b0;
        start_drain = 1'b0;
        release_ir  = 1'b0;
        case (state)
            IDLE: begin
                state_next = FETCH;
            end
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ack && !redirect) begin
                    capture    = 1'b1;
                    state_next = FULL;
                end else if (!mem_ack && redirect) begin
                    start_drain = 1'b1;
                    state_next  = DRAIN;
                end
            end
            DRAIN: begin
                mem_req  = 1'b1;
                mem_addr = drain_addr;
                if (mem_ack) begin
                    state_next = FETCH;
                end
            end
            FULL: begin
                if (ir_ready || redirect) begin
                    release_ir = 1'b1;
                    state_next = FETCH;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The PC is frozen by reloading its own value; only a clean ack in FETCH lets it step
    always_comb begin
        pc_ld      = 1'b1;
        pc_ld_addr = pc_in;
        if (rst) begin
            if (redirect) begin
                pc_ld_addr = redirect_addr;
            end else if (state == FETCH && mem_ack) begin
                pc_ld = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a behavioural PC and a
// configurable-latency memory that returns addr ^ 16'hA5A5.
module tb_instruction_fetch;

    logic        clk;
    logic        rst;
    logic [15:0] pc_in;
    logic        pc_ld;
    logic [15:0] pc_ld_addr;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_data;
    logic [15:0] ir_out;
    logic [15:0] instr_addr;
    logic        ir_valid;
    logic        ir_ready;
    logic        redirect;
    logic [15:0] redirect_addr;

    logic        pc_set;
    logic [1:0]  mem_wait;
    logic [1:0]  wait_cnt;

    int checks;
    int errors;

    instruction_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .pc_in         (pc_in),
        .pc_ld         (pc_ld),
        .pc_ld_addr    (pc_ld_addr),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_data      (mem_data),
        .ir_out        (ir_out),
        .instr_addr    (instr_addr),
        .ir_valid      (ir_valid),
        .ir_ready      (ir_ready),
        .redirect      (redirect),
        .redirect_addr (redirect_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program counter obeying the load/increment contract
    always @(posedge clk) begin
        if (pc_set)
            pc_in <= 16'h0000;
        else
            pc_in <= pc_ld ? pc_ld_addr : pc_in + 16'd1;
    end

    // Memory acks after mem_wait cycles of a held request
    assign mem_ack  = mem_req && (wait_cnt == mem_wait);
    assign mem_data = mem_addr ^ 16'hA5A5;

    always @(posedge clk) begin
        if (!mem_req || mem_ack)
            wait_cnt <= 2'd0;
        else
            wait_cnt <= wait_cnt + 2'd1;
    end

    task automatic check_output(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b0;
        pc_set        = 1'b1;
        pc_in         = 16'h0000;
        wait_cnt      = 2'd0;
        mem_wait      = 2'd0;
        ir_ready      = 1'b1;
        redirect      = 1'b0;
        redirect_addr = 16'h0000;

        step();
        step();
        check_output("rst_ir_valid", {15'd0, ir_valid}, 16'd0);
        check_output("rst_mem_req", {15'd0, mem_req}, 16'd0);
        check_output("rst_pc_ld", {15'd0, pc_ld}, 16'd1);
        check_output("rst_ir_out", ir_out, 16'h0000);
        check_output("rst_instr_addr", instr_addr, 16'h0000);

        // Release: one IDLE cycle, then requests start
        rst    = 1'b1;
        pc_set = 1'b0;
        #1;
        check_output("idle_mem_req", {15'd0, mem_req}, 16'd0);
        step();
        for (int i = 0; i < 3; i++) begin
            check_output("zw_mem_req", {15'd0, mem_req}, 16'd1);
            check_output("zw_mem_addr", mem_addr, 16'(i));
            check_output("zw_valid_low", {15'd0, ir_valid}, 16'd0);
            step();
            check_output("zw_valid", {15'd0, ir_valid}, 16'd1);
            check_output("zw_ir_out", ir_out, 16'(i) ^ 16'hA5A5);
            check_output("zw_instr_addr", instr_addr, 16'(i));
            if (i < 2) step();
        end

        // Three-cycle memory wait: address and PC stay put
        mem_wait = 2'd3;
        step();
        for (int k = 0; k < 3; k++) begin
            check_output("wait_mem_addr", mem_addr, 16'h0003);
            check_output("wait_pc", pc_in, 16'h0003);
            check_output("wait_pc_ld", {15'd0, pc_ld}, 16'd1);
            step();
        end
        check_output("wait_ack_adv", {15'd0, pc_ld}, 16'd0);
        step();
        check_output("wait_ir_out", ir_out, 16'hA5A6);

        // Decode stall for four cycles
        ir_ready = 1'b0;
        mem_wait = 2'd0;
        for (int k = 0; k < 4; k++) begin
            step();
            check_output("stall_valid", {15'd0, ir_valid}, 16'd1);
            check_output("stall_ir_out", ir_out, 16'hA5A6);
            check_output("stall_instr_addr", instr_addr, 16'h0003);
            check_output("stall_pc", pc_in, 16'h0004);
        end
        ir_ready = 1'b1;
        step();
        check_output("addr4_mem_addr", mem_addr, 16'h0004);
        step();
        mem_wait = 2'd3;
        step();

        // Redirect in FETCH before the ack: drain the orphan at 5
        check_output("pre_drain_addr", mem_addr, 16'h0005);
        redirect      = 1'b1;
        redirect_addr = 16'h0100;
        #1;
        check_output("redir_pc_ld", {15'd0, pc_ld}, 16'd1);
        check_output("redir_pc_ld_addr", pc_ld_addr, 16'h0100);
        step();
        redirect = 1'b0;
        check_output("drain_mem_req", {15'd0, mem_req}, 16'd1);
        check_output("drain_mem_addr", mem_addr, 16'h0005);
        check_output("drain_pc", pc_in, 16'h0100);
        check_output("drain_valid", {15'd0, ir_valid}, 16'd0);
        step();
        step();
        check_output("drain_ack", {15'd0, mem_ack}, 16'd1);
        check_output("drain_no_adv", {15'd0, pc_ld}, 16'd1);
        step();
        mem_wait = 2'd0;
        check_output("post_drain_addr", mem_addr, 16'h0100);
        check_output("post_drain_valid", {15'd0, ir_valid}, 16'd0);
        step();
        check_output("tgt_ir_out", ir_out, 16'hA4A5);
        check_output("tgt_instr_addr", instr_addr, 16'h0100);

        // Redirect coincident with ack in FETCH
        step();
        redirect      = 1'b1;
        redirect_addr = 16'h0200;
        #1;
        check_output("coinc_pc_ld_addr", pc_ld_addr, 16'h0200);
        step();
        redirect = 1'b0;
        check_output("coinc_valid", {15'd0, ir_valid}, 16'd0);
        check_output("coinc_mem_addr", mem_addr, 16'h0200);
        check_output("coinc_ir_kept", ir_out, 16'hA4A5);
        step();
        check_output("coinc_ir_out", ir_out, 16'hA7A5);

        // Redirect in FULL while decode is stalled
        ir_ready      = 1'b0;
        redirect      = 1'b1;
        redirect_addr = 16'h0300;
        step();
        redirect = 1'b0;
        ir_ready = 1'b1;
        check_output("full_redir_valid", {15'd0, ir_valid}, 16'd0);
        check_output("full_redir_addr", mem_addr, 16'h0300);
        step();
        check_output("full_redir_ir", ir_out, 16'hA6A5);

        // Wrap from FFFF to 0000
        redirect      = 1'b1;
        redirect_addr = 16'hFFFF;
        step();
        redirect = 1'b0;
        step();
        check_output("wrap_ir_ffff", ir_out, 16'h5A5A);
        check_output("wrap_addr_ffff", instr_addr, 16'hFFFF);
        step();
        check_output("wrap_mem_addr", mem_addr, 16'h0000);
        step();
        check_output("wrap_ir_0", ir_out, 16'hA5A5);
        check_output("wrap_addr_0", instr_addr, 16'h0000);

        // Asynchronous reset in the middle of a drain
        mem_wait = 2'd3;
        step();
        redirect      = 1'b1;
        redirect_addr = 16'h0400;
        step();
        redirect = 1'b0;
        check_output("ar_in_drain", mem_addr, 16'h0001);
        #2;
        rst = 1'b0;
        #1;
        check_output("ar_valid", {15'd0, ir_valid}, 16'd0);
        check_output("ar_mem_req", {15'd0, mem_req}, 16'd0);
        check_output("ar_pc_ld", {15'd0, pc_ld}, 16'd1);
        check_output("ar_pc_ld_addr", pc_ld_addr, 16'h0400);
        step();
        rst      = 1'b1;
        mem_wait = 2'd0;
        #1;
        check_output("ar_idle_req", {15'd0, mem_req}, 16'd0);
        step();
        check_output("ar_resume_addr", mem_addr, 16'h0400);
        step();
        check_output("ar_ir_out", ir_out, 16'hA1A5);
        check_output("ar_instr_addr", instr_addr, 16'h0400);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
